ex_muldiv_iter: RTL and testbench
=================================

Name: ex_muldiv_iter

Overview:
Iterative RV32M/RV64M multiply/divide unit sitting beside the single-cycle execute stage. Accepts one operation at a time from ID/EX, computes it bit-serially over XLEN cycles, and holds the pipeline via a stall request. Returns the result with its destination register to the EX/MEM write-back path. Supports flush from branch resolution.

Parameters:
XLEN, 32, operand/result width; 32 or 64.
REGW, 5, destination register address width.
CNTW, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
start_i  input  1  request a new operation; sampled only in IDLE.
op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
a_i  input  XLEN  rs1 operand.
b_i  input  XLEN  rs2 operand.
wd_i  input  REGW  destination register.
flush_i  input  1  abort the current operation; no write-back.
busy_o  output  1  high while state != IDLE.
stall_o  output  1  pipeline hold request.
done_o  output  1  one-cycle result-valid pulse.
result_o  output  XLEN  result, valid when done_o=1; held until the next accepted start.
wd_o  output  REGW  destination latched at start.
wreg_o  output  1  equals done_o.

Behaviour:
- Reset: state=IDLE; busy_o, stall_o, done_o, wreg_o = 0; result_o=0, wd_o=0. Reset mid-operation discards all work.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start_i + !flush_i: latch op, wd_i, |a_i|, |b_i| (abs for signed ops; MULHSU takes abs of a only) and the result sign. Load counter with XLEN. Go to CALC, or to DONE for special cases.
- CALC, multiply: shift-add, 2*XLEN accumulator, one multiplier bit per cycle.
- CALC, divide: restoring, one quotient bit per cycle.
- Counter decrements each CALC cycle; at 1 go to FIX.
- FIX: apply two's-complement sign correction and select the result. MUL takes low XLEN bits; MULH* take high XLEN bits. DIV* give the quotient; REM* give the remainder, whose sign follows the dividend. Go to DONE.
- DONE: done_o=wreg_o=1 for exactly one cycle; result_o registered. Return to IDLE. A start_i in DONE is ignored and not accepted until IDLE.
- Latency: start sampled at edge T gives done_o high in the cycle after edge T+XLEN+2 (XLEN CALC + FIX + DONE).
- Divide special cases (detected at start, skip CALC/FIX, done in cycle after edge T+1):
  - b=0: DIV/DIVU quotient = all ones; REM/REMU result = a.
  - Signed overflow (a = most-negative, b = -1): DIV result = a; REM result = 0.
- stall_o = (state is CALC or FIX) OR (state==IDLE AND start_i AND !flush_i). It is combinational, so the issuing instruction freezes ID/EX in its own cycle. It is low during DONE so the pipeline advances with the result.
- flush_i in any non-IDLE state: go to IDLE at the next edge. No done_o; result_o unchanged.
- flush_i and start_i together in IDLE: flush wins; nothing is accepted.
- Arithmetic is unsigned internally on XLEN+1 bits for the divide subtract. Signed/unsigned handling is confined to the entry abs step and the FIX step.

Test Plan:
- MUL a=7, b=-3 (XLEN=32) -> done_o at cycle T+34, result_o=0xFFFFFFEB, wd_o = the latched wd_i, stall_o high cycles T..T+33.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done_o at T+2. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- Start DIV, assert flush_i at T+10 -> busy_o low next cycle, no done_o, result_o keeps its previous value. A new start at T+12 completes normally.
- Assert rst at T+5 of a MUL -> all outputs 0 at the next edge. Back-to-back starts with start_i held high -> the second is accepted only after DONE, the two done pulses are XLEN+3 cycles apart, and the results are correct.

Source files
------------

// File: rtl/ex_muldiv_iter_if.sv
// ex_muldiv_iter_if
//   Request/response bundle between ID/EX and the iterative mul/div unit.
//   master : issuing pipeline side (drives *_i, observes *_o)
//   slave  : ex_muldiv_iter (observes *_i, drives *_o)
//   Signals:
//     start_i   request a new operation
//     op_i      0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//     a_i/b_i   rs1/rs2 operands
//     wd_i      destination register
//     flush_i   abort the operation in flight
//     busy_o    unit not idle
//     stall_o   pipeline hold request
//     done_o    one-cycle result-valid pulse
//     result_o  result, held until the next completion
//     wd_o      destination latched at start
//     wreg_o    write-back enable (same as done_o)
interface ex_muldiv_iter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [REGW-1:0] wd_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [REGW-1:0] wd_o;
  logic            wreg_o;

  modport master (
    output start_i, op_i, a_i, b_i, wd_i, flush_i,
    input  busy_o, stall_o, done_o, result_o, wd_o, wreg_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, wd_i, flush_i,
    output busy_o, stall_o, done_o, result_o, wd_o, wreg_o
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter
//   Iterative RV32M/RV64M multiply/divide unit beside the execute stage.
//   One operation at a time; XLEN bit-serial iterations, then a sign-fix
//   cycle, then a DONE cycle that registers the result and raises done_o
//   for one cycle. Divide-by-zero and signed overflow bypass the iterations.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  ex_muldiv_iter_if.slave (request, flush, stall/done/result)
module ex_muldiv_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_iter_if.slave bus
);

  localparam int unsigned CNTW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [2:0]        op_q;
  logic [REGW-1:0]   wd_q;
  logic [XLEN-1:0]   opx_q;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc_q;     // mul: {partial, multiplier}; div: {rem, quotient}
  logic [CNTW-1:0]   cnt_q;
  logic              negq_q;    // negate product / quotient in FIX
  logic              negr_q;    // negate remainder in FIX
  logic [XLEN-1:0]   fix_q;     // result awaiting the DONE cycle
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  // ---------------------------------------------------------------
  // Entry decode: operand magnitudes, signs and special cases
  // ---------------------------------------------------------------
  logic              accept;
  logic              is_div;
  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              b_zero;
  logic              ovf;
  logic [XLEN-1:0]   special_res;

  assign accept = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;

  always_comb begin
    is_div = bus.op_i[2];
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    case (bus.op_i)
      3'd1, 3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2:    a_sgn = 1'b1;
      default: ;
    endcase
    abs_a  = (a_sgn && bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
    abs_b  = (b_sgn && bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;
    b_zero = is_div && (bus.b_i == '0);
    // op_i[0]==0 within the divide group selects the signed forms
    ovf    = is_div && !bus.op_i[0] && (bus.a_i == MIN_NEG) && (bus.b_i == '1);
    special_res = '0;
    if (b_zero) begin
      special_res = bus.op_i[1] ? bus.a_i : '1;
    end else if (ovf) begin
      special_res = bus.op_i[1] ? '0 : bus.a_i;
    end
  end

  // ---------------------------------------------------------------
  // Iteration step and sign-fix result
  // ---------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] acc_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_d;

  always_comb begin
    // shift-add: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opx_q} : '0);
    // restoring divide: bring in the next dividend bit and try a subtract;
    // the remainder stays below the divisor so XLEN bits hold the difference
    div_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = (div_sh >= {1'b0, opx_q});
    div_diff = div_sh[XLEN-1:0] - opx_q;
    if (op_q[2]) begin
      acc_d = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                     : {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod = negq_q ? -acc_q : acc_q;
    quo  = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:             fix_d = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_d = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_d = quo;
      default:          fix_d = rem;
    endcase
  end

  // ---------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      wd_q     <= '0;
      opx_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      fix_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= bus.op_i;
            wd_q   <= bus.wd_i;
            negq_q <= (a_sgn && bus.a_i[XLEN-1]) ^ (b_sgn && bus.b_i[XLEN-1]);
            negr_q <= a_sgn && bus.a_i[XLEN-1];
            cnt_q  <= CNTW'(XLEN);
            if (is_div) begin
              opx_q <= abs_b;
              acc_q <= {{XLEN{1'b0}}, abs_a};
            end else begin
              opx_q <= abs_a;
              acc_q <= {{XLEN{1'b0}}, abs_b};
            end
            if (b_zero || ovf) begin
              fix_q   <= special_res;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNTW'(1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            fix_q   <= fix_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // result_o only changes on a completed, unflushed operation
          if (!bus.flush_i) begin
            result_q <= fix_q;
            done_q   <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.stall_o  = (state_q == S_CALC) || (state_q == S_FIX) || accept;
  assign bus.done_o   = done_q;
  assign bus.wreg_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.wd_o     = wd_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
module tb_ex_muldiv_iter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic clk;
  logic rst;

  ex_muldiv_iter_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  ex_muldiv_iter #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [REGW-1:0] wd;
    int              due;
  } exp_t;

  exp_t exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 64'(bus.result_o), 64'(e.res));
        check("wd", 64'(bus.wd_o), 64'(e.wd));
        check("wreg", 64'(bus.wreg_o), 64'd1);
        check("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [REGW-1:0] wd, input logic [XLEN-1:0] res,
                       input bit special, input bit expect_done);
    exp_t e;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.wd_i    = wd;
    bus.start_i = 1'b1;
    if (expect_done) begin
      e.res = res;
      e.wd  = wd;
      e.due = cyc + (special ? 2 : XLEN + 3);
      exp_q.push_back(e);
      last_res = res;
    end
    #1;
    check("stall_issue", 64'(bus.stall_o), 64'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [REGW-1:0] wd, input logic [XLEN-1:0] res, input bit special);
    issue(op, a, b, wd, res, special, 1'b1);
    repeat (special ? 2 : XLEN + 3) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    bit              special;
  } vec_t;

  vec_t vecs[] = '{
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},  // MULH
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},  // MULHU
    '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0},  // MULHSU
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},  // MULH -1*-1
    '{3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0},  // MUL wraps
    '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},  // DIV -7/2
    '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},  // REM -7/2
    '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},  // DIV 7/-2
    '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0},  // REM 7/-2
    '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0},  // DIVU
    '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0},  // REMU
    '{3'd5, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0},  // DIVU by 1
    '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1},  // DIVU /0
    '{3'd6, 32'd5,        32'd0,        32'd5,        1'b1},  // REM /0
    '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1},  // DIV -5/0
    '{3'd7, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b1},  // REMU /0
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},  // DIV overflow
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}   // REM overflow
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000 (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int c0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = '0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.wd_i    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_wreg", 64'(bus.wreg_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_wd", 64'(bus.wd_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7 * -3 with stall window measured
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 1'b0, 1'b1);
    sc = 1;
    repeat (XLEN + 3) begin
      if (bus.stall_o) sc++;
      @(negedge clk);
    end
    check("mul_stall_cycles", 64'(sc), 64'(XLEN + 2));

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 4), vecs[i].res, vecs[i].special);
    end

    // flush mid-divide, then a fresh start two cycles later
    c0 = cyc;
    issue(3'd4, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    check("flush_result_kept", 64'(bus.result_o), 64'(last_res));
    @(negedge clk);
    check("flush_restart_cycle", 64'(cyc - c0), 64'd12);
    run_op(3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0);

    // flush and start together in IDLE: nothing accepted
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    check("flush_start_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_start_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) @(negedge clk);

    // flush while in DONE suppresses the pulse and keeps result_o
    issue(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 1'b1, 1'b0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_done_busy", 64'(bus.busy_o), 64'd0);
    check("flush_done_result", 64'(bus.result_o), 64'(last_res));
    repeat (3) @(negedge clk);

    // reset in the middle of a MUL
    issue(3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_stall", 64'(bus.stall_o), 64'd0);
    check("mid_rst_done", 64'(bus.done_o), 64'd0);
    check("mid_rst_result", 64'(bus.result_o), 64'd0);
    check("mid_rst_wd", 64'(bus.wd_o), 64'd0);
    rst = 1'b0;
    last_res = '0;
    repeat (2) @(negedge clk);

    // back-to-back with start_i held: second accepted only once IDLE again
    begin
      exp_t e;
      c0 = cyc;
      bus.op_i    = 3'd3;
      bus.a_i     = 32'hFFFFFFFF;
      bus.b_i     = 32'hFFFFFFFF;
      bus.wd_i    = 5'd10;
      bus.start_i = 1'b1;
      e.res = 32'hFFFFFFFE; e.wd = 5'd10; e.due = c0 + XLEN + 3;
      exp_q.push_back(e);
      @(negedge clk);
      bus.op_i = 3'd5;
      bus.a_i  = 32'd100;
      bus.b_i  = 32'd7;
      bus.wd_i = 5'd11;
      e.res = 32'd14; e.wd = 5'd11; e.due = c0 + 2 * (XLEN + 3);
      exp_q.push_back(e);
      repeat (XLEN + 3) @(negedge clk);
      bus.start_i = 1'b0;
      repeat (XLEN + 6) @(negedge clk);
    end

    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
